// File: rtl/memd_responder_pkg.sv
// Shared parameters for the data-memory load responder: default widths,
// the latency bound and the custom reset image of the memd array.
package memd_responder_pkg;

  localparam int unsigned MEMD_SIZE_LOG_DFLT = 2;
  localparam int unsigned REG_LEN_DFLT       = 8;
  localparam int unsigned ROB_SIZE_LOG_DFLT  = 3;
  localparam int unsigned LATENCY_DFLT       = 2;
  localparam int unsigned LATENCY_MAX        = 4;

  localparam int unsigned INIT_LEN = 4;
  localparam int unsigned INIT_WORDS [INIT_LEN] = '{2, 3, 3, 3};

  // Reset-time word for one address; addresses past the image read as zero.
  function automatic int unsigned init_word(input int unsigned addr,
                                            input int unsigned custom);
    if (custom != 0 && addr < INIT_LEN) begin
      return INIT_WORDS[addr];
    end
    return 0;
  endfunction

endpackage

// File: rtl/memd_resp_stage.sv
// One slice of the load-response pipeline: holds {valid, tag, addr}.
// Flush drops only the valid bit; stall (adv=0) holds the whole slice.
module memd_resp_stage #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_adv,
  input  logic              i_flush,
  input  logic              i_v,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_v,
  output logic [TAG_W-1:0]  o_tag,
  output logic [ADDR_W-1:0] o_addr
);

  logic              r_v;
  logic [TAG_W-1:0]  r_tag;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v    <= 1'b0;
      r_tag  <= '0;
      r_addr <= '0;
    end else if (i_flush) begin
      r_v <= 1'b0;
    end else if (i_adv) begin
      r_v    <= i_v;
      r_tag  <= i_tag;
      r_addr <= i_addr;
    end
  end

  assign o_v    = r_v;
  assign o_tag  = r_tag;
  assign o_addr = r_addr;

endmodule

// File: rtl/memd_responder.sv
// Responder for tagged data-memory loads: fixed-latency pipeline in front of a
// read-only memd array, with global stall on response backpressure and flush.
module memd_responder
  import memd_responder_pkg::*;
#(
  parameter int unsigned MEMD_SIZE_LOG = MEMD_SIZE_LOG_DFLT,
  parameter int unsigned REG_LEN       = REG_LEN_DFLT,
  parameter int unsigned ROB_SIZE_LOG  = ROB_SIZE_LOG_DFLT,
  parameter int unsigned LATENCY       = LATENCY_DFLT,
  parameter int unsigned INIT_CUSTOM   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [MEMD_SIZE_LOG-1:0] req_addr,
  input  logic [ROB_SIZE_LOG-1:0]  req_tag,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ROB_SIZE_LOG-1:0]  resp_tag,
  output logic [REG_LEN-1:0]       resp_data,
  output logic [2:0]               inflight
);

  localparam int unsigned DEPTH = 1 << MEMD_SIZE_LOG;

  // Stage inputs and outputs live in separate arrays so the accept path
  // (output valid -> adv -> req_ready -> stage-0 input) never forms a
  // combinational loop at signal granularity.
  logic [LATENCY-1:0]       w_in_v;
  logic [ROB_SIZE_LOG-1:0]  w_in_tag  [LATENCY];
  logic [MEMD_SIZE_LOG-1:0] w_in_addr [LATENCY];
  logic [LATENCY-1:0]       w_out_v;
  logic [ROB_SIZE_LOG-1:0]  w_out_tag  [LATENCY];
  logic [MEMD_SIZE_LOG-1:0] w_out_addr [LATENCY];

  logic [REG_LEN-1:0] r_mem [DEPTH];
  logic [REG_LEN-1:0] r_data;
  logic               w_adv;
  logic               w_accept;
  logic [2:0]         w_cnt;
  logic               w_unused;

  assign w_adv     = !w_out_v[LATENCY-1] || resp_ready;
  assign req_ready = w_adv && !flush && !rst;
  assign w_accept  = req_valid && req_ready;

  assign w_in_v[0]    = w_accept;
  assign w_in_tag[0]  = req_tag;
  assign w_in_addr[0] = req_addr;

  for (genvar k = 1; k < LATENCY; k++) begin : g_link
    assign w_in_v[k]    = w_out_v[k-1];
    assign w_in_tag[k]  = w_out_tag[k-1];
    assign w_in_addr[k] = w_out_addr[k-1];
  end

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    memd_resp_stage #(
      .ADDR_W (MEMD_SIZE_LOG),
      .TAG_W  (ROB_SIZE_LOG)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_adv   (w_adv),
      .i_flush (flush),
      .i_v     (w_in_v[k]),
      .i_tag   (w_in_tag[k]),
      .i_addr  (w_in_addr[k]),
      .o_v     (w_out_v[k]),
      .o_tag   (w_out_tag[k]),
      .o_addr  (w_out_addr[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        r_mem[a] <= REG_LEN'(init_word(a, INIT_CUSTOM));
      end
    end
  end

  // The array is read as an entry moves into the last stage; for a one-stage
  // pipeline that stage's input is the request itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_adv && !flush) begin
      r_data <= r_mem[w_in_addr[LATENCY-1]];
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      w_cnt = w_cnt + 3'(w_out_v[k]);
    end
  end

  assign w_unused   = ^w_out_addr[LATENCY-1];
  assign resp_valid = w_out_v[LATENCY-1];
  assign resp_tag   = w_out_tag[LATENCY-1];
  assign resp_data  = r_data;
  assign inflight   = w_cnt;

endmodule

// File: doc/memd_responder.md
Name: memd_responder

Overview:
- Responder end of the core's data-memory load interface. The ROB issues tagged load requests; this block returns the tagged data after a configurable fixed latency.
- Holds the data-memory array, including its reset-time contents.
- Supports response backpressure and a squash flush that discards all in-flight loads.
- Sits between the OOO core's execute/load path and the memd storage.

Parameters:
- MEMD_SIZE_LOG, 2, address width; array depth is 2**MEMD_SIZE_LOG.
- REG_LEN, 8, data word width.
- ROB_SIZE_LOG, 3, width of the request/response tag (ROB index).
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..4.
- INIT_CUSTOM, 0, selects reset contents: 0 = all zero; 1 = words {2,3,3,3} at addresses 0..3, all others zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  load request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_addr  in  MEMD_SIZE_LOG  load address.
- req_tag  in  ROB_SIZE_LOG  ROB index of the requesting entry.
- flush  in  1  squash; discards all in-flight and same-cycle requests.
- resp_valid  out  1  response present.
- resp_ready  in  1  core consumes the response when resp_valid && resp_ready.
- resp_tag  out  ROB_SIZE_LOG  tag of the response.
- resp_data  out  REG_LEN  loaded word.
- inflight  out  3  number of valid pipeline stages, 0..LATENCY.

Behaviour:
- Reset, asserted asynchronously:
  - all stage valid bits are cleared; resp_valid=0, resp_tag=0, resp_data=0, inflight=0.
  - the array is loaded per INIT_CUSTOM.
  - req_ready is 1 once rst deasserts.
- Pipeline structure:
  - Stages s1..sL with L=LATENCY; each stage holds {v, tag, addr}, and sL also holds data.
  - resp_valid=v[L], resp_tag=tag[L], resp_data=data[L].
- Advance and stall:
  - adv = !v[L] || resp_ready.
  - When adv=1, every stage shifts by one: s1 captures the request, s(k+1) captures sk.
  - When adv=0, the whole pipeline holds. Bubbles do not collapse; this is a global stall.
- Request acceptance:
  - req_ready = adv && !flush (combinational).
  - An accepted request enters s1 with v=1. If no request is accepted while adv=1, s1 gets v=0.
- Data capture:
  - The array is read at addr when an entry moves into sL. For L=1 the read happens at acceptance, using req_addr.
  - Captured data is held stable while stalled.
- Latency:
  - A request accepted at edge t gives resp_valid=1 after edge t+L-1. L=1 means the response is visible in the cycle after acceptance.
  - With resp_ready held at 1, one response is returned per cycle.
- Flush:
  - At the edge where flush=1, all v bits are cleared, including v[L] even if resp_ready=1 in that cycle. The response is not considered consumed.
  - A request presented in the same cycle is not accepted (req_ready=0).
  - Flush has priority over stall and advance.
  - resp_tag and resp_data keep their stale values; only resp_valid carries meaning.
- inflight: popcount of the v bits, updated at the same edge as the v bits.
- Back-to-back operation: accept and consume in the same cycle is allowed, and is full throughput at L stages.
- Address wrap: addresses are exactly MEMD_SIZE_LOG bits, so no out-of-range case exists.
- Writes: the array is read-only after reset. There is no write port in this revision.
- Reset mid-operation: everything clears immediately and asynchronously. No response is emitted for requests that were in flight.

Decomposition:
- Shared parameter header, the existing param include, provides:
  - MEMD_SIZE_LOG, REG_LEN, ROB_SIZE_LOG;
  - the INIT_CUSTOM contents {2,3,3,3};
  - the LATENCY upper bound.
- One natural sub-module, memd_resp_stage: a single pipeline register slice {v, tag, addr}, with stall and flush inputs and an async reset. It is instantiated LATENCY times via generate.
- The array and the final data capture stay in the top module.

Test Plan:
- Reset contents: INIT_CUSTOM=1, L=2, resp_ready=1. Request addr=1 tag=5 at cycle 0 → resp_valid=1, tag=5, data=3 in cycle 2, then resp_valid=0 in cycle 3.
- Streaming: L=2, resp_ready=1, requests addr 0,1,2,3 with tags 0..3 in cycles 0..3 → responses data 2,3,3,3 with tags 0..3 in cycles 2..5; inflight is 2 in cycles 2..4.
- Backpressure: L=2, resp_ready=0 from cycle 2. Requests in cycles 0,1,2 → cycle 2 shows tag0 stable; req_ready=0 from cycle 2 while the pipeline is full. Raising resp_ready at cycle 5 → tag0 in cycle 5, tag1 in cycle 6, no loss or duplication.
- Flush: two requests in flight plus a new request, with flush=1 in cycle 1 → req_ready=0 in cycle 1, inflight=0 and resp_valid=0 in cycle 2, and nothing is returned afterward.
- Async reset: assert rst mid-stream between clock edges → resp_valid=0 and inflight=0 immediately, without waiting for a clock edge.
- L=1: request addr=0 at cycle 0 → data=2 valid in cycle 1. Requests every cycle with resp_ready=1 → one response per cycle.
